// File: rtl/tc_lfsr8_ctrl.sv
// tc_lfsr8_ctrl: command sequencer for the 8-bit LFSR (taps 4/5/6, right shift,
// serial-in at bit 7). It runs one command at a time (SEED, SHIFT, RUN, CAPTURE),
// holds the LFSR frozen between commands, pulses DONE with RESULT when a command
// completes, and flags an all-zero lockup seen while stepping.
// Optional feature macro: TC_LFSR_CTRL_CMP_EN adds the MATCH output, which
// compares the captured value against the CAPTURE command's data.
module tc_lfsr8_ctrl #(
  parameter int CNT_W = 5
) (
  input  logic             phi,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [7:0]       CMD_DATA,
  input  logic [CNT_W-1:0] CMD_CNT,
  input  logic [7:0]       LFSR_OUT,
  output logic             SET_EN,
  output logic [7:0]       SET_VAL,
  output logic             SI,
  output logic             SI_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [7:0]       RESULT,
`ifdef TC_LFSR_CTRL_CMP_EN
  output logic             MATCH,
`endif
  output logic             LOCKUP
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED  = 3'd1,
    S_SHIFT = 3'd2,
    S_RUN   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [1:0] OP_SEED  = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_CAP   = 2'b11;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       data_q, data_nxt;
  logic [CNT_W-1:0] shift_n;
  logic             accept;

  assign CMD_READY = (state == S_IDLE);
  assign BUSY      = (state != S_IDLE);
  assign accept    = CMD_VALID && (state == S_IDLE);

  // The LFSR can only be frozen by reloading its own output, so SET_VAL
  // carries the seed only in SEED and mirrors LFSR_OUT everywhere else.
  assign SET_VAL   = (state == S_SEED) ? data_q : LFSR_OUT;

  // Next-state: latch the command on accept, count down remaining steps/bits.
  // SHIFT data is shifted right each cycle so bit 0 is always the next bit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_q;
    shift_n   = (CMD_CNT > CNT_W'(8)) ? CNT_W'(8) : CMD_CNT;
    case (state)
      S_IDLE: begin
        if (accept) begin
          data_nxt = CMD_DATA;
          case (CMD_OP)
            OP_SEED:  state_nxt = S_SEED;
            OP_SHIFT: begin
              cnt_nxt   = shift_n;
              state_nxt = (shift_n == '0) ? S_FIN : S_SHIFT;
            end
            OP_RUN: begin
              cnt_nxt   = CMD_CNT;
              state_nxt = (CMD_CNT == '0) ? S_FIN : S_RUN;
            end
            default:  state_nxt = S_FIN;
          endcase
        end
      end
      S_SEED:  state_nxt = S_FIN;
      S_SHIFT: begin
        data_nxt = {1'b0, data_q[7:1]};
        cnt_nxt  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = S_FIN;
      end
      S_RUN: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = S_FIN;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counter and latched data registers.
  always_ff @(posedge phi or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      cnt    <= '0;
      data_q <= 8'h00;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      data_q <= data_nxt;
    end
  end

  // Registered LFSR controls, decoded from the state being entered so they
  // line up with that state's cycle. Reset leaves the LFSR in hold.
  always_ff @(posedge phi or negedge RST_N) begin
    if (!RST_N) begin
      SET_EN <= 1'b1;
      SI_EN  <= 1'b0;
      SI     <= 1'b0;
    end else begin
      SET_EN <= !((state_nxt == S_SHIFT) || (state_nxt == S_RUN));
      SI_EN  <= (state_nxt == S_SHIFT);
      SI     <= (state_nxt == S_SHIFT) && data_nxt[0];
    end
  end

  // Completion: capture the result on the closing edge of FIN, pulse DONE.
  always_ff @(posedge phi or negedge RST_N) begin
    if (!RST_N) begin
      DONE   <= 1'b0;
      RESULT <= 8'h00;
    end else begin
      DONE <= (state == S_FIN);
      if (state == S_FIN) RESULT <= LFSR_OUT;
    end
  end

  // Sticky lockup: any all-zero value while stepping; only a nonzero seed clears it.
  always_ff @(posedge phi or negedge RST_N) begin
    if (!RST_N)
      LOCKUP <= 1'b0;
    else if ((state == S_RUN) && (LFSR_OUT == 8'h00))
      LOCKUP <= 1'b1;
    else if (accept && (CMD_OP == OP_SEED) && (CMD_DATA != 8'h00))
      LOCKUP <= 1'b0;
  end

`ifdef TC_LFSR_CTRL_CMP_EN
  logic [1:0] op_q;

  // Compare result: only a CAPTURE can produce a match; other commands clear it.
  always_ff @(posedge phi or negedge RST_N) begin
    if (!RST_N) begin
      op_q  <= OP_SEED;
      MATCH <= 1'b0;
    end else begin
      if (accept) op_q <= CMD_OP;
      if (state == S_FIN) MATCH <= (op_q == OP_CAP) && (LFSR_OUT == data_q);
    end
  end
`endif

endmodule

// File: tb/tb_tc_lfsr8_ctrl.sv
// Bench for tc_lfsr8_ctrl: a behavioural LFSR closes the loop, a driver issues
// directed and random commands while predicting each completion from a
// command-level model, and a monitor checks every DONE against that queue.
module tb_tc_lfsr8_ctrl;

  logic       phi = 1'b0;
  logic       RST_N = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [1:0] CMD_OP = 2'b00;
  logic [7:0] CMD_DATA = 8'h00;
  logic [4:0] CMD_CNT = 5'd0;
  logic [7:0] LFSR_OUT;
  logic       SET_EN, SI, SI_EN, BUSY, DONE, LOCKUP;
  logic [7:0] SET_VAL, RESULT;
`ifdef TC_LFSR_CTRL_CMP_EN
  logic       MATCH;
`endif

  tc_lfsr8_ctrl #(.CNT_W(5)) dut (
    .phi(phi), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .CMD_CNT(CMD_CNT), .LFSR_OUT(LFSR_OUT),
    .SET_EN(SET_EN), .SET_VAL(SET_VAL), .SI(SI), .SI_EN(SI_EN), .BUSY(BUSY),
    .DONE(DONE), .RESULT(RESULT),
`ifdef TC_LFSR_CTRL_CMP_EN
    .MATCH(MATCH),
`endif
    .LOCKUP(LOCKUP)
  );

  always #5 phi = ~phi;

  // The LFSR being controlled; it has no reset of its own.
  logic [7:0] lfsr = 8'h00;
  always @(posedge phi) begin
    if (SET_EN)     lfsr <= SET_VAL;
    else if (SI_EN) lfsr <= {SI, lfsr[7:1]};
    else            lfsr <= {lfsr[0], lfsr[7:1]} ^ (lfsr[0] ? 8'h38 : 8'h00);
  end
  assign LFSR_OUT = lfsr;

  int cyc = 0;
  always @(posedge phi) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] res;
    logic       lock;
    logic       match;
    int         lat;
    int         acc;
  } exp_t;
  exp_t q[$];

  // Command-level reference state.
  logic [7:0] m_lfsr = 8'h00;
  logic       m_lock = 1'b0;

  function automatic logic [7:0] step(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predict the command's outcome, then drive it and queue the expectation.
  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [4:0] c,
                       input bit track, input bit glitch);
    exp_t e;
    int   n, v, guard;
    e.match = 1'b0;
    case (op)
      2'b00: begin
        m_lfsr = d;
        if (d != 8'h00) m_lock = 1'b0;
        e.lat = 3;
      end
      2'b01: begin
        n = (c > 5'd8) ? 8 : int'(c);
        v = int'(m_lfsr);
        v = (v >> n) | ((int'(d) & ((1 << n) - 1)) << (8 - n));
        m_lfsr = v[7:0];
        e.lat = n + 2;
      end
      2'b10: begin
        for (int i = 0; i < int'(c); i++) begin
          if (m_lfsr == 8'h00) m_lock = 1'b1;
          m_lfsr = step(m_lfsr);
        end
        e.lat = int'(c) + 2;
      end
      default: begin
        e.match = (d == m_lfsr);
        e.lat = 2;
      end
    endcase
    e.res  = m_lfsr;
    e.lock = m_lock;

    guard = 0;
    @(negedge phi);
    while (!CMD_READY && guard < 200) begin
      @(negedge phi);
      guard++;
    end
    if (!CMD_READY) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_DATA  = d;
    CMD_CNT   = c;
    e.acc     = cyc + 1;
    if (track) q.push_back(e);
    @(negedge phi);
    chk("busy_after_accept", BUSY, 1'b1);
    chk("ready_after_accept", CMD_READY, 1'b0);
    if (glitch) begin
      // Garbage request while busy must be ignored.
      CMD_OP   = 2'($urandom_range(0, 3));
      CMD_DATA = 8'($urandom);
      CMD_CNT  = 5'($urandom);
      @(negedge phi);
    end
    CMD_VALID = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge phi);
      t++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  // Monitor: every DONE pulse is matched against the oldest expectation.
  always @(negedge phi) begin
    exp_t e;
    if (RST_N && DONE) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        chk("result", RESULT, e.res);
        chk("lockup", LOCKUP, e.lock);
        chk("latency", cyc - e.acc + 1, e.lat);
`ifdef TC_LFSR_CTRL_CMP_EN
        chk("match", MATCH, e.match);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] op;
    logic [7:0] d;
    logic [4:0] c;
    #2 RST_N = 1'b0;
    repeat (3) @(negedge phi);
    chk("rst_ready", CMD_READY, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_result", RESULT, 8'h00);
    chk("rst_lockup", LOCKUP, 1'b0);
    chk("rst_ctrl", {SET_EN, SI_EN, SI}, 3'b100);
    RST_N = 1'b1;
    @(negedge phi);
    chk("idle_setval", SET_VAL, LFSR_OUT);

    // Directed sequences.
    issue(2'b00, 8'h01, 5'd0, 1, 0);
    issue(2'b10, 8'h00, 5'd1, 1, 0);
    issue(2'b00, 8'h01, 5'd0, 1, 0);
    issue(2'b10, 8'h00, 5'd2, 1, 1);
    issue(2'b00, 8'h00, 5'd0, 1, 0);
    issue(2'b01, 8'hA5, 5'd8, 1, 0);
    issue(2'b00, 8'h00, 5'd0, 1, 0);
    issue(2'b01, 8'h0F, 5'd4, 1, 0);
    issue(2'b00, 8'h00, 5'd0, 1, 0);
    issue(2'b01, 8'h5A, 5'd12, 1, 0);
    issue(2'b00, 8'h3C, 5'd0, 1, 0);
    drain();
    repeat (10) @(negedge phi);
    chk("idle_frozen", LFSR_OUT, 8'h3C);
    issue(2'b11, 8'h3C, 5'd0, 1, 0);
    issue(2'b11, 8'h3D, 5'd0, 1, 0);
    issue(2'b00, 8'h00, 5'd0, 1, 0);
    issue(2'b10, 8'h00, 5'd3, 1, 0);
    issue(2'b00, 8'h01, 5'd0, 1, 0);
    issue(2'b10, 8'h00, 5'd0, 1, 0);
    issue(2'b01, 8'h00, 5'd0, 1, 0);
    drain();

    // Reset in the third step of a 20-step run: LFSR stays at two steps from 0x01.
    issue(2'b00, 8'h01, 5'd0, 1, 0);
    drain();
    issue(2'b10, 8'h00, 5'd20, 0, 0);
    repeat (2) @(negedge phi);
    RST_N = 1'b0;
    #1;
    chk("midrst_ready", CMD_READY, 1'b1);
    chk("midrst_ctrl", {SET_EN, SI_EN, SI}, 3'b100);
    repeat (4) begin
      @(negedge phi);
      chk("midrst_done", DONE, 1'b0);
      chk("midrst_frozen", LFSR_OUT, 8'h5C);
    end
    RST_N = 1'b1;
    m_lfsr = 8'h5C;
    m_lock = 1'b0;
    repeat (3) begin
      @(negedge phi);
      chk("postrst_done", DONE, 1'b0);
    end
    issue(2'b11, 8'h5C, 5'd0, 1, 0);
    drain();

    // Random commands with random gaps and ignored requests while busy.
    for (int k = 0; k < 150; k++) begin
      op = 2'($urandom_range(0, 3));
      d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      c  = (op == 2'b01) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 31));
      if (op == 2'b11 && $urandom_range(0, 1) == 1) d = m_lfsr;
      issue(op, d, c, 1, bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge phi);
    end
    drain();
    chk("final_lfsr", LFSR_OUT, m_lfsr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tc_lfsr8_ctrl.md
Name: tc_lfsr8_ctrl

Overview:
Command-driven sequencer for the 8-bit LFSR block (taps 4/5/6, right-shifting, serial-in at bit 7). It accepts one command at a time over a valid/ready handshake and drives the LFSR's SET_EN, SET_VAL, SI and SI_EN: seed load, serial shift-in, N free-running steps, or capture. It reports completion with a DONE pulse and an 8-bit RESULT, and flags all-zero lockup. The LFSR has no hold mode (SET_EN=SI_EN=0 always steps), so this block also freezes it between commands.

Parameters:
CNT_W, 5, width of CMD_CNT; RUN supports 0..2^CNT_W-1 steps

Ports:
phi  in  1  clock; LFSR and controller both update on posedge
RST_N  in  1  reset, asynchronous, active-low
CMD_VALID  in  1  command request
CMD_READY  out  1  high only in IDLE; command accepted on posedge when CMD_VALID&CMD_READY
CMD_OP  in  2  00 SEED, 01 SHIFT, 10 RUN, 11 CAPTURE
CMD_DATA  in  8  seed value (SEED) / serial data, LSB first (SHIFT) / compare value (CAPTURE, optional)
CMD_CNT  in  CNT_W  bit count (SHIFT, clamped to 8) / step count (RUN)
LFSR_OUT  in  8  LFSR OUT
SET_EN  out  1  to LFSR
SET_VAL  out  8  to LFSR
SI  out  1  to LFSR
SI_EN  out  1  to LFSR
BUSY  out  1  high in any state other than IDLE
DONE  out  1  one-cycle pulse, command complete
RESULT  out  8  LFSR_OUT captured at completion
LOCKUP  out  1  sticky: all-zero state seen during RUN

Behaviour:
- States: IDLE, SEED, SHIFT, RUN, FIN. Command fields are latched on accept; the next state is selected by CMD_OP, and CAPTURE goes directly to FIN.
- IDLE/FIN (hold): SET_EN=1, SET_VAL=LFSR_OUT (combinational reload), SI_EN=0, SI=0. The LFSR never changes outside an active state.
- SEED: one cycle with SET_EN=1, SET_VAL=latched data, then FIN.
- SHIFT: n=min(CMD_CNT,8) cycles with SI_EN=1, SET_EN=0, SI=data[i] for i=0..n-1, then FIN. n=0 goes directly to FIN.
- RUN: N cycles with SET_EN=0 and SI_EN=0 (one LFSR step per cycle), then FIN. N=0 goes directly to FIN. A down-counter holds the remaining count.
- FIN: one hold cycle. On its closing edge: RESULT<=LFSR_OUT, DONE<=1, state<=IDLE. DONE is high for exactly the first IDLE cycle after FIN, and a new command may be accepted in that same cycle.
- Latency, accept edge to DONE-high cycle: SEED 3; SHIFT n+2; RUN N+2; CAPTURE 2.
- LOCKUP: set when LFSR_OUT==8'h00 in any RUN cycle; cleared on acceptance of SEED with nonzero data. It is not cleared by SHIFT/CAPTURE.
- Reset (any time, including mid-command): state IDLE, CMD_READY=1, BUSY=0, DONE=0, RESULT=8'h00, LOCKUP=0, SI=0, SI_EN=0, SET_EN=1 with SET_VAL=LFSR_OUT. The LFSR contents are held, not cleared; a partially executed command is abandoned with no DONE.
- CMD_VALID while BUSY is ignored; no queueing.
- SI, SI_EN and SET_EN are registered outputs. SET_VAL is muxed between the latched data and LFSR_OUT.

Optional Feature:
TC_LFSR_CTRL_CMP_EN
- Defined: adds output MATCH (1 bit, reset 0). On the FIN closing edge of a CAPTURE command, MATCH<=(LFSR_OUT==latched CMD_DATA); MATCH<=0 for all other commands. MATCH is valid in the same cycle as DONE.
- Undefined: no MATCH port and no comparator; CAPTURE only loads RESULT.

Test Plan:
- Reset then SEED 0x01 -> DONE in 3rd cycle after accept, RESULT=0x01, LOCKUP=0.
- SEED 0x01, RUN CNT=1 -> RESULT=0xB8; repeat from 0x01 with RUN CNT=2 -> RESULT=0x5C, DONE 4 cycles after RUN accept.
- SEED 0x00, SHIFT data 0xA5 CNT=8 -> RESULT=0xA5; SEED 0x00, SHIFT data 0x0F CNT=4 -> 0xF0; SHIFT CNT=12 behaves as CNT=8.
- SEED 0x3C, idle 10 cycles with CMD_VALID=0, CAPTURE -> RESULT=0x3C (no free-run); with CMP_EN, CAPTURE data 0x3C -> MATCH=1, data 0x3D -> MATCH=0.
- SEED 0x00, RUN CNT=3 -> RESULT=0x00, LOCKUP=1; then SEED 0x01 -> LOCKUP=0. RUN CNT=0 -> DONE in 2nd cycle, LFSR unchanged.
- Assert RST_N=0 during the 3rd step of RUN CNT=20 -> no DONE pulse, CMD_READY=1, LFSR_OUT frozen at its value at reset; next CAPTURE returns that value.
